xc_mask_seq: RTL and testbench

Multi-cycle sequencer for two-share masked operations in the SCARV masking unit. Accepts one request at a time carrying two shares per operand, steps a single registered share datapath through a fixed per-op schedule, draws fresh randomness from an external RNG port with stall, and holds the resulting share pair until the consumer accepts it. Sits between the execute-stage masked-instruction decoder and the writeback of the wide (`rd`, `rd_hi`) register pair.

---
 rtl/xc_mask_seq_if.sv | 35 +++
 rtl/xc_mask_seq.sv | 170 +++++++++++++++++
 tb/tb_xc_mask_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/xc_mask_seq_if.sv
// Request / RNG / response bundle for the two-share masked-op sequencer.
// master: request issuer, RNG source and result consumer. slave: the sequencer.
interface xc_mask_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a0;
  logic [31:0] req_a1;
  logic [31:0] req_b0;
  logic [31:0] req_b1;
  logic        rng_valid;
  logic [31:0] rng_data;
  logic        rng_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_s0;
  logic [31:0] rsp_s1;
  logic        busy;

  modport master (
    output req_valid, req_op,
    output req_a0, req_a1, req_b0, req_b1,
    output rng_valid, rng_data, rsp_ready,
    input  req_ready, rng_ready,
    input  rsp_valid, rsp_s0, rsp_s1, busy
  );

  modport slave (
    input  req_valid, req_op,
    input  req_a0, req_a1, req_b0, req_b1,
    input  rng_valid, rng_data, rsp_ready,
    output req_ready, rng_ready,
    output rsp_valid, rsp_s0, rsp_s1, busy
  );
endinterface

// File: rtl/xc_mask_seq.sv
// Two-share masked NOT / AND / B2A sequencer with RNG stall.
// Ports: g_clk, g_rst (async high), bus (xc_mask_seq_if.slave).
// XC_MASK_SEQ_REFRESH_EN adds a final share-refresh step.
module xc_mask_seq (
  input  logic         g_clk,
  input  logic         g_rst,
  xc_mask_seq_if.slave bus
);
  localparam logic [1:0] OP_NOT = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_B2A = 2'd2;

`ifdef XC_MASK_SEQ_REFRESH_EN
  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_RSP, S_REFR
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_RSP
  } state_t;
`endif

  state_t      state_q;
  logic [1:0]  op_q;
  logic [2:0]  step_q;
  logic [31:0] a0_q, a1_q;
  logic [31:0] b0_q, b1_q;
  logic [31:0] z0_q, z1_q;
  logic [31:0] t_q, g_q;

  logic [2:0]  last_step;
  logic        rnd_step;
  logic        stall;
  logic [31:0] r;

  always_comb begin
    last_step = 3'd0;
    case (op_q)
      OP_AND:  last_step = 3'd2;
      OP_B2A:  last_step = 3'd6;
      default: last_step = 3'd0;
    endcase
  end

  // Only the first AND/B2A step (and refresh) draws randomness.
  always_comb begin
    rnd_step = (state_q == S_EXEC) &&
               (step_q == 3'd0) &&
               (op_q == OP_AND ||
                op_q == OP_B2A);
`ifdef XC_MASK_SEQ_REFRESH_EN
    if (state_q == S_REFR)
      rnd_step = 1'b1;
`endif
  end

  assign stall = rnd_step & ~bus.rng_valid;
  assign r     = bus.rng_data;

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_valid = (state_q == S_RSP);
  assign bus.rng_ready = rnd_step;
  assign bus.rsp_s0    = z0_q;
  assign bus.rsp_s1    = z1_q;

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      step_q  <= 3'd0;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      z0_q    <= '0;
      z1_q    <= '0;
      t_q     <= '0;
      g_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            a0_q    <= bus.req_a0;
            a1_q    <= bus.req_a1;
            b0_q    <= bus.req_b0;
            b1_q    <= bus.req_b1;
            step_q  <= 3'd0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            case (op_q)
              OP_NOT: begin
                z0_q <= a0_q;
                z1_q <= ~a1_q;
              end
              OP_AND: begin
                case (step_q)
                  3'd0: begin
                    z0_q <= (a0_q & b0_q) ^ r;
                    t_q  <= r ^ (a0_q & b1_q);
                  end
                  3'd1:
                    t_q  <= t_q ^ (a1_q & b0_q);
                  3'd2:
                    z1_q <= t_q ^ (a1_q & b1_q);
                  default: ;
                endcase
              end
              OP_B2A: begin
                case (step_q)
                  3'd0: begin
                    g_q <= r;
                    t_q <= a0_q ^ r;
                  end
                  3'd1: t_q  <= t_q - g_q;
                  3'd2: t_q  <= t_q ^ a0_q;
                  3'd3: g_q  <= g_q ^ a1_q;
                  3'd4: z0_q <= a0_q ^ g_q;
                  3'd5: z0_q <= z0_q - g_q;
                  3'd6: begin
                    z0_q <= z0_q ^ t_q;
                    z1_q <= a1_q;
                  end
                  default: ;
                endcase
              end
              default: begin
                z0_q <= '0;
                z1_q <= '0;
              end
            endcase
            if (step_q == last_step) begin
`ifdef XC_MASK_SEQ_REFRESH_EN
              state_q <= S_REFR;
`else
              state_q <= S_RSP;
`endif
            end else begin
              step_q <= step_q + 3'd1;
            end
          end
        end
`ifdef XC_MASK_SEQ_REFRESH_EN
        S_REFR: begin
          if (!stall) begin
            // Arithmetic shares re-mask additively.
            if (op_q == OP_B2A) begin
              z0_q <= z0_q - r;
              z1_q <= z1_q + r;
            end else begin
              z0_q <= z0_q ^ r;
              z1_q <= z1_q ^ r;
            end
            state_q <= S_RSP;
          end
        end
`endif
        S_RSP: begin
          if (bus.rsp_ready)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xc_mask_seq.sv
// Directed self-checking bench for xc_mask_seq.
// Expected values are hand-computed shares and latencies.
module tb_xc_mask_seq;
  logic clk;
  logic rst;
  int   tests;
  int   failed;
  int   lat;

`ifdef XC_MASK_SEQ_REFRESH_EN
  localparam int          RF     = 1;
  localparam logic [31:0] B2A_S0 = 32'hFFFF_FFF3;
  localparam logic [31:0] B2A_S1 = 32'h0000_0013;
`else
  localparam int          RF     = 0;
  localparam logic [31:0] B2A_S0 = 32'h0000_0003;
  localparam logic [31:0] B2A_S1 = 32'h0000_0003;
`endif

  xc_mask_seq_if bus ();

  xc_mask_seq dut (
    .g_clk (clk),
    .g_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Issue one request; rng words r1 then r2;
  // rng_valid low for the first dly EXEC cycles.
  // lat counts cycles from accept to first rsp_valid.
  task automatic do_req(
    input  logic [1:0]  op,
    input  logic [31:0] a0, a1, b0, b1,
    input  logic [31:0] r1, r2,
    input  int          dly,
    input  logic        rdy,
    output int          l
  );
    int idx;
    idx = 0;
    bus.req_op    = op;
    bus.req_a0    = a0;
    bus.req_a1    = a1;
    bus.req_b0    = b0;
    bus.req_b1    = b1;
    bus.rsp_ready = rdy;
    bus.rng_valid = 1'b0;
    bus.rng_data  = r1;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    l = 1;
    for (int c = 0; c < 60; c++) begin
      bus.rng_valid = (c >= dly);
      bus.rng_data  = (idx == 0) ? r1 : r2;
      if (c < dly)
        chk("rng_ready_stall",
            {31'd0, bus.rng_ready}, 32'd1);
      #1;
      if (bus.rng_ready && bus.rng_valid)
        idx++;
      @(posedge clk);
      #1;
      l++;
      if (bus.rsp_valid) break;
    end
    if (!bus.rsp_valid)
      chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    tests         = 0;
    failed        = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_a0    = '0;
    bus.req_a1    = '0;
    bus.req_b0    = '0;
    bus.req_b1    = '0;
    bus.rng_valid = 1'b0;
    bus.rng_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rng_ready", {31'd0, bus.rng_ready}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_s0", bus.rsp_s0, 32'd0);
    chk("rst_s1", bus.rsp_s1, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // NOT with 5 cycles of backpressure
    do_req(2'd0, 32'h0000_00FF, 32'h1234_5678,
           32'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0, lat);
    chk("not_lat", lat, 2 + RF);
    for (int i = 0; i < 5; i++) begin
      chk("not_s0", bus.rsp_s0, 32'h0000_00FF);
      chk("not_s1", bus.rsp_s1, 32'hEDCB_A987);
      chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("bp_busy", {31'd0, bus.busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("not_done_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("not_done_ready", {31'd0, bus.req_ready}, 32'd1);

    // AND, rsp_ready high before response
    do_req(2'd1, 32'hFFFF_0000, 32'h00FF_00FF,
           32'h0F0F_0F0F, 32'd0,
           32'hA5A5_A5A5, 32'd0, 0, 1'b1, lat);
    chk("and_lat", lat, 4 + RF);
    chk("and_s0", bus.rsp_s0, 32'hAAAA_A5A5);
    chk("and_xor", bus.rsp_s0 ^ bus.rsp_s1, 32'h0F00_000F);
    @(posedge clk);
    #1;
    chk("and_hs_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("and_hs_ready", {31'd0, bus.req_ready}, 32'd1);

    // B2A
    do_req(2'd2, 32'h0000_0005, 32'h0000_0003,
           32'd0, 32'd0,
           32'hDEAD_BEEF, 32'h0000_0010, 0, 1'b1, lat);
    chk("b2a_lat", lat, 8 + RF);
    chk("b2a_s0", bus.rsp_s0, B2A_S0);
    chk("b2a_s1", bus.rsp_s1, B2A_S1);
    chk("b2a_sum", bus.rsp_s0 + bus.rsp_s1, 32'd6);
    @(posedge clk);
    #1;

    // AND with 3 RNG stall cycles in S1
    do_req(2'd1, 32'hFFFF_0000, 32'h00FF_00FF,
           32'h0F0F_0F0F, 32'd0,
           32'hA5A5_A5A5, 32'd0, 3, 1'b1, lat);
    chk("stall_lat", lat, 7 + RF);
    chk("stall_s0", bus.rsp_s0, 32'hAAAA_A5A5);
    chk("stall_s1", bus.rsp_s1, 32'hA5AA_A5AA);
    @(posedge clk);
    #1;

    // Reserved op clears the result
    do_req(2'd3, 32'h1111_1111, 32'h2222_2222,
           32'h3333_3333, 32'h4444_4444,
           32'd0, 32'd0, 0, 1'b1, lat);
    chk("rsv_lat", lat, 2 + RF);
    chk("rsv_s0", bus.rsp_s0, 32'd0);
    chk("rsv_s1", bus.rsp_s1, 32'd0);
    @(posedge clk);
    #1;

    // Reset pulsed during B2A step B4
    bus.req_op    = 2'd2;
    bus.req_a0    = 32'h0000_0005;
    bus.req_a1    = 32'h0000_0003;
    bus.rng_data  = 32'hDEAD_BEEF;
    bus.rng_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_b4_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_b4_rngr", {31'd0, bus.rng_ready}, 32'd0);
    chk("rst_b4_s0", bus.rsp_s0, 32'd0);
    chk("rst_b4_s1", bus.rsp_s1, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("rst_b4_norsp", {31'd0, bus.rsp_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, failed);
    $finish;
  end
endmodule
